// File: rtl/jogo_pkg.sv
// Shared definitions for the parametrised game controller: state encoding
// (values double as db_estado debug codes) and width/score helper functions.
package jogo_pkg;

  typedef enum logic [4:0] {
    INICIAL       = 5'h00,
    PREPARA       = 5'h01,
    PAUSA_RODADA  = 5'h02,
    ESPERA_JOGADA = 5'h03,
    COMPARA       = 5'h05,
    TOCA_NOTA     = 5'h07,
    PAUSA_NOTA    = 5'h08,
    FIM_GANHOU    = 5'h0A,
    FIM_RODADA    = 5'h0B,
    ERROU         = 5'h0E,
    FIM_PERDEU    = 5'h0F,
    ESPERA_SOLTAR = 5'h12,
    TREINO        = 5'h16
  } estado_t;

  localparam int DB_W = 5;

  // ROM address / round index width; never narrower than one bit
  function automatic int largura_endereco(input int max_rodadas);
    return (max_rodadas > 1) ? $clog2(max_rodadas) : 1;
  endfunction

  // Error counter width, able to hold 0..max_erros
  function automatic int largura_erros(input int max_erros);
    return (max_erros > 0) ? $clog2(max_erros + 1) : 1;
  endfunction

  // Counter width able to hold 0..limite
  function automatic int largura_contador(input int limite);
    return (limite > 0) ? $clog2(limite + 1) : 1;
  endfunction

  // Score subtraction that stops at zero instead of wrapping
  function automatic int subtrai_saturado(input int a, input int b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/temporizador_param.sv
// Cycle timer: counts while conta=1, clears on zera; fim flags the last
// counted cycle (count == limite-1) so the caller can leave its state.
module temporizador_param #(
  parameter int LIMITE_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                zera,
  input  logic                conta,
  input  logic [LIMITE_W-1:0] limite,
  output logic                fim
);

  logic [LIMITE_W-1:0] contagem;

  // Count register with synchronous clear taking priority over counting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta) begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim = conta && (contagem == (limite - 1'b1));

endmodule

// File: rtl/jogo_controlador_param.sv
// Game controller: plays a growing one-hot note sequence from ROM, checks the
// player's presses, tracks lives and score. Optional build macro
// JOGO_ACELERA_EN shortens the playback note as rounds advance.
module jogo_controlador_param
  import jogo_pkg::*;
#(
  parameter int N_BOTOES    = 4,
  parameter int MAX_RODADAS = 16,
  parameter int MAX_ERROS   = 3,
  parameter int T_NOTA      = 50_000_000,
  parameter int T_PAUSA     = 12_500_000,
  parameter int T_JOGADA    = 250_000_000,
  parameter int PONTOS_W    = 8,
  parameter int PONTOS_INI  = 100,
  parameter int PENALIDADE  = 10,
  localparam int ADDR_W     = largura_endereco(MAX_RODADAS),
  localparam int ERROS_W    = largura_erros(MAX_ERROS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                treinamento,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [ADDR_W-1:0]   mem_endereco,
  output logic [N_BOTOES-1:0] nota_out,
  output logic                tocando,
  output logic [ADDR_W-1:0]   rodada,
  output logic [ERROS_W-1:0]  erros,
  output logic [PONTOS_W-1:0] pontos,
  output logic                pronto,
  output logic                acertou,
  output logic                perdeu,
  output logic [DB_W-1:0]     db_estado
);

  localparam int T_MAX_NOTA = (T_NOTA > T_PAUSA) ? T_NOTA : T_PAUSA;
  localparam int NOTA_W     = largura_contador(T_MAX_NOTA);
  localparam int JOGADA_W   = largura_contador(T_JOGADA);

  estado_t estado, estado_prox;

  logic [N_BOTOES-1:0] botoes_ant;
  logic [N_BOTOES-1:0] jogada;
  logic                evento;
  logic                ultimo;
  logic                ultima_rodada;
  logic                acerto;

  logic                conta_nota, zera_nota, fim_nota;
  logic [NOTA_W-1:0]   limite_nota, t_nota_atual;
  logic                conta_jog, zera_jog, fim_jog;

  assign evento        = (|botoes) && !(|botoes_ant);
  assign ultimo        = (mem_endereco == rodada);
  assign ultima_rodada = (rodada == ADDR_W'(MAX_RODADAS - 1));
  assign acerto        = (jogada == mem_dado);

`ifdef JOGO_ACELERA_EN
  localparam int PASSO = T_NOTA / MAX_RODADAS;
  localparam int T_MIN = T_NOTA / 4;

  logic [NOTA_W-1:0] t_nota_reg;

  function automatic int duracao_nota(input int r);
    int t;
    t = T_NOTA - r * PASSO;
    return (t < T_MIN) ? T_MIN : t;
  endfunction

  // Note length for the upcoming round, refreshed when the round changes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      t_nota_reg <= NOTA_W'(T_NOTA);
    end else if (estado == PREPARA) begin
      t_nota_reg <= NOTA_W'(T_NOTA);
    end else if (estado == FIM_RODADA && !ultima_rodada) begin
      t_nota_reg <= NOTA_W'(duracao_nota(int'(rodada) + 1));
    end
  end

  assign t_nota_atual = t_nota_reg;
`else
  assign t_nota_atual = NOTA_W'(T_NOTA);
`endif

  // One timer serves note, note pause and round pause; it restarts whenever
  // it expires or the FSM is outside those states.
  assign conta_nota  = (estado == TOCA_NOTA) || (estado == PAUSA_NOTA) ||
                       (estado == PAUSA_RODADA);
  assign zera_nota   = !conta_nota || fim_nota;
  assign limite_nota = (estado == TOCA_NOTA) ? t_nota_atual : NOTA_W'(T_PAUSA);

  assign conta_jog = (estado == ESPERA_JOGADA);
  assign zera_jog  = !conta_jog;

  temporizador_param #(.LIMITE_W(NOTA_W)) u_tempo_nota (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera_nota),
    .conta  (conta_nota),
    .limite (limite_nota),
    .fim    (fim_nota)
  );

  temporizador_param #(.LIMITE_W(JOGADA_W)) u_tempo_jogada (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera_jog),
    .conta  (conta_jog),
    .limite (JOGADA_W'(T_JOGADA)),
    .fim    (fim_jog)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    estado_prox = estado;
    nota_out    = '0;
    tocando     = 1'b0;
    case (estado)
      INICIAL:       if (jogar) estado_prox = PREPARA;
      PREPARA:       estado_prox = treinamento ? TREINO : TOCA_NOTA;
      TOCA_NOTA: begin
        nota_out = mem_dado;
        tocando  = 1'b1;
        if (fim_nota) estado_prox = PAUSA_NOTA;
      end
      PAUSA_NOTA:    if (fim_nota) estado_prox = ultimo ? ESPERA_JOGADA : TOCA_NOTA;
      ESPERA_JOGADA: begin
        if (evento)       estado_prox = ESPERA_SOLTAR;
        else if (fim_jog) estado_prox = ERROU;
      end
      ESPERA_SOLTAR: begin
        nota_out = jogada;
        if (botoes == '0) estado_prox = COMPARA;
      end
      COMPARA: begin
        if (!acerto)     estado_prox = ERROU;
        else if (ultimo) estado_prox = FIM_RODADA;
        else             estado_prox = ESPERA_JOGADA;
      end
      ERROU:         estado_prox = (erros == ERROS_W'(MAX_ERROS - 1)) ? FIM_PERDEU : PAUSA_RODADA;
      FIM_RODADA:    estado_prox = ultima_rodada ? FIM_GANHOU : PAUSA_RODADA;
      PAUSA_RODADA:  if (fim_nota) estado_prox = TOCA_NOTA;
      FIM_GANHOU:    if (jogar) estado_prox = PREPARA;
      FIM_PERDEU:    if (jogar) estado_prox = PREPARA;
      TREINO: begin
        nota_out = botoes;
        tocando  = |botoes;
        if (!treinamento) estado_prox = INICIAL;
      end
      default:       estado_prox = INICIAL;
    endcase
  end

  // Round, address, error, score and captured-move registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes_ant   <= '0;
      jogada       <= '0;
      rodada       <= '0;
      mem_endereco <= '0;
      erros        <= '0;
      pontos       <= '0;
    end else begin
      botoes_ant <= botoes;
      case (estado)
        PREPARA: begin
          rodada       <= '0;
          mem_endereco <= '0;
          erros        <= '0;
          pontos       <= PONTOS_W'(PONTOS_INI);
        end
        PAUSA_NOTA: begin
          if (fim_nota) begin
            if (ultimo) mem_endereco <= '0;
            else        mem_endereco <= mem_endereco + 1'b1;
          end
        end
        ESPERA_JOGADA: if (evento) jogada <= botoes;
        COMPARA:       if (acerto && !ultimo) mem_endereco <= mem_endereco + 1'b1;
        ERROU: begin
          erros        <= erros + 1'b1;
          pontos       <= PONTOS_W'(subtrai_saturado(int'(pontos), PENALIDADE));
          mem_endereco <= '0;
        end
        FIM_RODADA: begin
          if (!ultima_rodada) rodada <= rodada + 1'b1;
          mem_endereco <= '0;
        end
        default: ;
      endcase
    end
  end

  assign pronto    = (estado == FIM_GANHOU) || (estado == FIM_PERDEU);
  assign acertou   = (estado == FIM_GANHOU);
  assign perdeu    = (estado == FIM_PERDEU);
  assign db_estado = estado;

endmodule
